// File: rtl/clock_pkg.sv
// Purpose: shared mode encoding for the clock's user-input front end and the sec/min/hour counters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_pkg;

    // select_mode encoding, also decoded by count_sec and the minute/hour counters
    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_SEC  = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_HOUR = 2'b11
    } mode_t;

    // Mode button cycles RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> RUN
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_RUN:      n = MODE_SET_SEC;
            MODE_SET_SEC:  n = MODE_SET_MIN;
            MODE_SET_MIN:  n = MODE_SET_HOUR;
            default:       n = MODE_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/clock_btn_ctrl_debounce.sv
// Purpose: 2-FF synchroniser + stability counter debouncer for one raw push-button, with registered rise pulse.
// Latency: clean raw edge to btn_deb flip is DEB_CYCLES+2 clk; btn_rise is high the cycle after the flip edge.
// Backpressure: none; free-running, outputs are levels/pulses.
// Ports: clk, rst (async, active-high); btn_raw (asynchronous input);
//        btn_deb (debounced level); btn_rise (one-cycle pulse on debounced rising edge).
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_deb,
    output logic btn_rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] stab_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stab_cnt <= '0;
            btn_deb  <= 1'b0;
            btn_rise <= 1'b0;
        end else begin
            sync_q1  <= btn_raw;
            sync_q2  <= sync_q1;
            btn_rise <= 1'b0;
            if (sync_q2 == btn_deb) begin
                stab_cnt <= '0;
            end else if (stab_cnt == CW'(DEB_CYCLES - 1)) begin
                // This edge is the DEB_CYCLES-th consecutive differing sample: accept the new level.
                stab_cnt <= '0;
                btn_deb  <= sync_q2;
                btn_rise <= sync_q2;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_btn_ctrl.sv
// Purpose: clock user-input front end: debounces mode/up/down, runs the mode FSM, generates adjust strobes with auto-repeat and inactivity timeout.
// Latency: raw edge to select_mode/ena_up/ena_dw change is DEB_CYCLES+3 clk; repeat strobes follow ena_5hz by 1 clk.
// Backpressure: none; ena_up/ena_dw are one-cycle strobes with no handshake.
// Ports: clk, rst (async, active-high); ena (1 Hz strobe); ena_5hz (5 Hz strobe);
//        btn_mode/btn_up/btn_dw (raw buttons); select_mode (00 RUN, 01 SEC, 10 MIN, 11 HOUR);
//        ena_up/ena_dw (one-cycle increment/decrement strobes).
module clock_btn_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_TICKS  = 5,
    parameter int TIMEOUT_SEC = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       ena_5hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_dw,
    output logic [1:0] select_mode,
    output logic       ena_up,
    output logic       ena_dw
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int IW = $clog2(TIMEOUT_SEC + 1);

    logic deb_mode, deb_up, deb_dw;
    logic prs_mode, prs_up, prs_dw;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_mode),
        .btn_deb  (deb_mode),
        .btn_rise (prs_mode)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_up),
        .btn_deb  (deb_up),
        .btn_rise (prs_up)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dw (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_dw),
        .btn_deb  (deb_dw),
        .btn_rise (prs_dw)
    );

    mode_t         mode_q;
    logic [IW-1:0] idle_cnt;
    logic [HW-1:0] hold_up;
    logic [HW-1:0] hold_dw;

    logic any_press;
    logic both_held;
    logic adj_ok;
    logic up_fire;
    logic dw_fire;

    assign select_mode = mode_q;
    assign any_press   = prs_mode | prs_up | prs_dw;
    assign both_held   = deb_up & deb_dw;
    // Adjusting is only meaningful in a set mode; a simultaneous up+down hold or a mode
    // press in flight cancels any adjust activity for this cycle.
    assign adj_ok      = (mode_q != MODE_RUN) && !both_held && !prs_mode;
    // prs_x implies deb_x, so both_held also covers up and down pressed in the same cycle.
    assign up_fire     = adj_ok && (prs_up || (deb_up && ena_5hz && hold_up == HW'(HOLD_TICKS)));
    assign dw_fire     = adj_ok && (prs_dw || (deb_dw && ena_5hz && hold_dw == HW'(HOLD_TICKS)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_RUN;
            idle_cnt <= '0;
            hold_up  <= '0;
            hold_dw  <= '0;
            ena_up   <= 1'b0;
            ena_dw   <= 1'b0;
        end else begin
            ena_up <= up_fire;
            ena_dw <= dw_fire;

            // Mode press takes priority over a timeout expiring in the same cycle.
            if (prs_mode) begin
                mode_q   <= next_mode(mode_q);
                idle_cnt <= '0;
            end else if (mode_q != MODE_RUN && idle_cnt == IW'(TIMEOUT_SEC)) begin
                mode_q   <= MODE_RUN;
                idle_cnt <= '0;
            end else if (mode_q == MODE_RUN || any_press) begin
                idle_cnt <= '0;
            end else if (ena && idle_cnt != IW'(TIMEOUT_SEC)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // Hold counters saturate at HOLD_TICKS; once there, each ena_5hz fires a repeat.
            if (!adj_ok || !deb_up) begin
                hold_up <= '0;
            end else if (ena_5hz && hold_up != HW'(HOLD_TICKS)) begin
                hold_up <= hold_up + 1'b1;
            end

            if (!adj_ok || !deb_dw) begin
                hold_dw <= '0;
            end else if (ena_5hz && hold_dw != HW'(HOLD_TICKS)) begin
                hold_dw <= hold_dw + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_btn_ctrl.sv
module tb_clock_btn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic       ena_5hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dw = 1'b0;
    logic [1:0] select_mode;
    logic       ena_up;
    logic       ena_dw;

    int vectors = 0;
    int miscompares = 0;

    // Bench-controlled strobe phase: ena when cyc%100==99, ena_5hz when cyc%20==19.
    bit str_en = 1'b0;
    int cyc = 0;

    int up_cnt = 0;
    int dw_cnt = 0;
    int first_up = -1;
    int second_up = -1;
    int viol = 0;
    logic prev_up = 1'b0;
    logic prev_dw = 1'b0;

    clock_btn_ctrl #(
        .DEB_CYCLES  (4),
        .HOLD_TICKS  (2),
        .TIMEOUT_SEC (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .ena_5hz     (ena_5hz),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_dw      (btn_dw),
        .select_mode (select_mode),
        .ena_up      (ena_up),
        .ena_dw      (ena_dw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive strobes, take the edge, sample 1 time unit later.
    task automatic cycle();
        ena     = str_en && (cyc % 100 == 99);
        ena_5hz = str_en && (cyc % 20 == 19);
        @(posedge clk);
        #1;
        if (ena_up && ena_dw) viol++;
        if (ena_up && prev_up) viol++;
        if (ena_dw && prev_dw) viol++;
        prev_up = ena_up;
        prev_dw = ena_dw;
        if (ena_up) begin
            if (up_cnt == 0) first_up = cyc;
            else if (up_cnt == 1) second_up = cyc;
            up_cnt++;
        end
        if (ena_dw) dw_cnt++;
        cyc++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cycles(10);
        btn_mode = 1'b0;
        cycles(10);
    endtask

    task automatic clear_counts();
        up_cnt    = 0;
        dw_cnt    = 0;
        first_up  = -1;
        second_up = -1;
    endtask

    initial begin
        logic [1:0] exp_mode [4];
        exp_mode[0] = 2'b01;
        exp_mode[1] = 2'b10;
        exp_mode[2] = 2'b11;
        exp_mode[3] = 2'b00;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_mode", select_mode, 2'b00);
        check("rst_up", ena_up, 1'b0);
        check("rst_dw", ena_dw, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        cycles(3);
        check("post_rst_mode", select_mode, 2'b00);

        // 1: four mode presses, change exactly DEB_CYCLES+3 = 7 clk after raw edge
        for (int p = 0; p < 4; p++) begin
            btn_mode = 1'b1;
            cycles(6);
            check("mode_before_edge7", select_mode, (p == 0) ? 2'b00 : exp_mode[p-1]);
            cycles(1);
            check("mode_at_edge7", select_mode, exp_mode[p]);
            cycles(3);
            btn_mode = 1'b0;
            cycles(10);
        end

        // 2: glitches of 1..3 clk in SET_SEC are rejected
        press_mode();
        check("glitch_setup_mode", select_mode, 2'b01);
        clear_counts();
        for (int w = 1; w <= 3; w++) begin
            btn_up = 1'b1;
            cycles(w);
            btn_up = 1'b0;
            cycles(12);
        end
        check("glitch_up_pulses", up_cnt, 0);
        check("glitch_mode", select_mode, 2'b01);

        // 3: SET_MIN, hold up for 200 clk: press pulse + repeats on strobes 59,79,..,199
        press_mode();
        check("hold_setup_mode", select_mode, 2'b10);
        clear_counts();
        str_en = 1'b1;
        cyc = 0;
        btn_up = 1'b1;
        cycles(200);
        btn_up = 1'b0;
        check("hold_first_pulse_cyc", first_up, 6);
        check("hold_first_repeat_cyc", second_up, 59);
        check("hold_up_pulses", up_cnt, 9);
        cycles(60);
        check("hold_after_release", up_cnt, 9);
        check("hold_dw_pulses", dw_cnt, 0);
        str_en = 1'b0;

        // 4: RUN ignores a held down key
        press_mode();
        press_mode();
        check("run_setup_mode", select_mode, 2'b00);
        clear_counts();
        str_en = 1'b1;
        cyc = 0;
        btn_dw = 1'b1;
        cycles(120);
        btn_dw = 1'b0;
        cycles(10);
        str_en = 1'b0;
        check("run_dw_pulses", dw_cnt, 0);
        check("run_up_pulses", up_cnt, 0);

        // 5a: SET_HOUR idle timeout: idle reaches 3 after the ena at cyc 299, RUN one clk later
        press_mode();
        press_mode();
        press_mode();
        check("to_setup_mode", select_mode, 2'b11);
        str_en = 1'b1;
        cyc = 0;
        cycles(300);
        check("to_before_expiry", select_mode, 2'b11);
        cycles(1);
        check("to_after_expiry", select_mode, 2'b00);
        str_en = 1'b0;

        // 5b: mode press landing on the expiry cycle in SET_HOUR
        press_mode();
        press_mode();
        press_mode();
        check("col_h_setup_mode", select_mode, 2'b11);
        str_en = 1'b1;
        cyc = 0;
        cycles(294);
        btn_mode = 1'b1;
        cycles(6);
        check("col_h_before", select_mode, 2'b11);
        cycles(1);
        check("col_h_after", select_mode, 2'b00);
        cycles(3);
        btn_mode = 1'b0;
        cycles(10);
        str_en = 1'b0;

        // 5c: same collision in SET_SEC: press wins (SET_MIN), idle restarts from 0
        press_mode();
        check("col_s_setup_mode", select_mode, 2'b01);
        str_en = 1'b1;
        cyc = 0;
        cycles(294);
        btn_mode = 1'b1;
        cycles(6);
        check("col_s_before", select_mode, 2'b01);
        cycles(1);
        check("col_s_press_wins", select_mode, 2'b10);
        cycles(3);
        btn_mode = 1'b0;
        cycles(296);
        check("col_s_idle_restart", select_mode, 2'b10);
        cycles(1);
        check("col_s_timeout", select_mode, 2'b00);
        str_en = 1'b0;

        // 6: up+down together suppressed, then async reset mid-hold
        press_mode();
        check("both_setup_mode", select_mode, 2'b01);
        clear_counts();
        str_en = 1'b1;
        cyc = 0;
        btn_up = 1'b1;
        btn_dw = 1'b1;
        cycles(100);
        check("both_up_pulses", up_cnt, 0);
        check("both_dw_pulses", dw_cnt, 0);
        check("both_mode", select_mode, 2'b01);
        #3 rst = 1'b1;
        #1;
        check("async_rst_mode", select_mode, 2'b00);
        check("async_rst_up", ena_up, 1'b0);
        check("async_rst_dw", ena_dw, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        btn_up = 1'b0;
        btn_dw = 1'b0;
        str_en = 1'b0;
        cycles(20);
        check("post_rst2_mode", select_mode, 2'b00);

        check("strobe_rules", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
